dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/RV32I_definitions.sv | 69 ++++++
 rtl/dmem_ram.sv | 31 +++
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/RV32I_definitions.sv
// Shared RV32I definitions: memory op encodings, data-memory responder FSM states
// and the byte-lane helpers used to steer loads and stores.
package RV32I_definitions;

   typedef enum logic [2:0] {
      MEM_LB   = 3'd0,
      MEM_LH   = 3'd1,
      MEM_LW   = 3'd2,
      MEM_LB_U = 3'd3,
      MEM_LH_U = 3'd4,
      MEM_SB   = 3'd5,
      MEM_SH   = 3'd6,
      MEM_SW   = 3'd7
   } mem_op_e;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_e;

   function automatic mem_size_e op_size(input mem_op_e op);
      case (op)
         MEM_LB, MEM_LB_U, MEM_SB: return SZ_BYTE;
         MEM_LH, MEM_LH_U, MEM_SH: return SZ_HALF;
         default:                  return SZ_WORD;
      endcase
   endfunction

   function automatic logic [3:0] byte_enable(input mem_op_e op, input logic [1:0] lo);
      case (op_size(op))
         SZ_BYTE: return 4'b0001 << lo;
         SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Replicating the datum across lanes places it in every candidate lane; the
   // byte enables then pick the one actually written.
   function automatic logic [31:0] store_align(input mem_op_e op, input logic [31:0] data);
      case (op_size(op))
         SZ_BYTE: return {4{data[7:0]}};
         SZ_HALF: return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input mem_op_e op, input logic [1:0] lo,
                                                input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lo, 3'b000} +: 8];
      h = lo[1] ? word[31:16] : word[15:0];
      case (op)
         MEM_LB:   return {{24{b[7]}}, b};
         MEM_LB_U: return {24'h0, b};
         MEM_LH:   return {{16{h[15]}}, h};
         MEM_LH_U: return {16'h0, h};
         default:  return word;
      endcase
   endfunction

   function automatic logic misaligned(input mem_op_e op, input logic [1:0] lo);
      case (op_size(op))
         SZ_HALF: return lo[0];
         SZ_WORD: return lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data array with per-byte write enables and a registered read port.
module dmem_ram
   import RV32I_definitions::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              en,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // NOTE: the array and its read register carry no reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
         rdata_q <= mem[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, one-cycle response after WAIT_STATES+1.
// Define DMEM_MISALIGN_CHECK_EN to fault misaligned halfword/word accesses.
module dmem_responder
   import RV32I_definitions::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_wr_en,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_wr_data,
   output logic        rsp_valid,
   output logic [31:0] rsp_rd_data,
   output logic        rsp_err
);

   localparam int          ADDR_W     = $clog2(DEPTH_WORDS);
   localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

   dmem_state_e state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   mem_op_e     op_q, op_d;
   logic        wr_q, wr_d, err_q, err_d;

   logic        accept, go_resp, req_fault;
   logic [31:0] acc_addr, acc_wdata, ram_rdata;
   mem_op_e     acc_op;
   logic        acc_wr, acc_err;
   logic [3:0]  ram_we;

   assign req_ready = (state_q == IDLE) || (state_q == RESP);
   assign accept    = req_valid && req_ready;

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      req_fault = ({1'b0, req_addr} >= ADDR_LIMIT);
`ifdef DMEM_MISALIGN_CHECK_EN
      req_fault = req_fault | misaligned(mem_op_e'(req_op), req_addr[1:0]);
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      op_d    = op_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      case (state_q)
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: begin
            state_d = IDLE;
            if (accept) begin
               addr_d  = req_addr;
               op_d    = mem_op_e'(req_op);
               wr_d    = req_wr_en;
               wdata_d = req_wr_data;
               err_d   = req_fault;
               if (WAIT_STATES > 0) begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end else begin
                  state_d = RESP;
               end
            end
         end
      endcase
   end

   // The array is touched on the edge that enters RESP; with no wait states that is
   // the acceptance edge itself, so the live request fields feed the RAM directly.
   always_comb begin
      go_resp   = (accept && (WAIT_STATES == 0)) || (state_q == WAIT && cnt_q == 4'd0);
      acc_addr  = accept ? req_addr : addr_q;
      acc_op    = accept ? mem_op_e'(req_op) : op_q;
      acc_wr    = accept ? req_wr_en : wr_q;
      acc_wdata = accept ? req_wr_data : wdata_q;
      acc_err   = accept ? req_fault : err_q;
      ram_we    = 4'b0000;
      if (go_resp && acc_wr && !acc_err) ram_we = byte_enable(acc_op, acc_addr[1:0]);
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         op_q    <= MEM_LB;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (ADDR_W)
   ) u_ram (
      .clk   (Clk),
      .en    (go_resp),
      .we    (ram_we),
      .addr  (acc_addr[ADDR_W+1:2]),
      .wdata (store_align(acc_op, acc_wdata)),
      .rdata (ram_rdata)
   );

   assign rsp_valid   = (state_q == RESP);
   assign rsp_err     = rsp_valid && err_q;
   assign rsp_rd_data = (rsp_valid && !wr_q && !err_q) ?
                        load_extract(op_q, addr_q[1:0], ram_rdata) : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with no wait states, one with three.
module tb_dmem_responder;
   import RV32I_definitions::*;

   logic        Clk;
   logic        rst         [2];
   logic        req_valid   [2];
   logic        req_ready   [2];
   logic [31:0] req_addr    [2];
   logic        req_wr_en   [2];
   logic [2:0]  req_op      [2];
   logic [31:0] req_wr_data [2];
   logic        rsp_valid   [2];
   logic [31:0] rsp_rd_data [2];
   logic        rsp_err     [2];

   int n_checks = 0;
   int n_bad    = 0;

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
      .Clk(Clk), .Reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_addr(req_addr[0]), .req_wr_en(req_wr_en[0]), .req_op(req_op[0]),
      .req_wr_data(req_wr_data[0]), .rsp_valid(rsp_valid[0]), .rsp_rd_data(rsp_rd_data[0]),
      .rsp_err(rsp_err[0]));

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
      .Clk(Clk), .Reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_addr(req_addr[1]), .req_wr_en(req_wr_en[1]), .req_op(req_op[1]),
      .req_wr_data(req_wr_data[1]), .rsp_valid(rsp_valid[1]), .rsp_rd_data(rsp_rd_data[1]),
      .rsp_err(rsp_err[1]));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issues one request and returns the response and its latency in cycles after acceptance;
   // rdy records req_ready in the first four cycles after acceptance.
   task automatic access(input int d, input logic wr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat,
                         output logic [3:0] rdy);
      int budget;
      @(negedge Clk);
      budget = 0;
      while (!req_ready[d] && budget < 20) begin
         @(negedge Clk);
         budget++;
      end
      check("ready_before_req", req_ready[d], 1'b1);
      req_valid[d]   = 1'b1;
      req_wr_en[d]   = wr;
      req_op[d]      = op;
      req_addr[d]    = addr;
      req_wr_data[d] = wd;
      @(posedge Clk);
      #1 req_valid[d] = 1'b0;
      lat = 0;
      rd  = '0;
      err = 1'b0;
      rdy = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge Clk);
         if (i <= 4) rdy[i-1] = req_ready[d];
         if (rsp_valid[d]) begin
            lat = i;
            rd  = rsp_rd_data[d];
            err = rsp_err[d];
            break;
         end
      end
      if (lat == 0) check("rsp_timeout", 32'd0, 32'd1);
      @(negedge Clk);
      check("strobe_one_cycle", rsp_valid[d], 1'b0);
   endtask

   task automatic do_op(input string tag, input int d, input logic wr, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
      logic [31:0] rd;
      logic        err;
      int          lat;
      logic [3:0]  rdy;
      access(d, wr, op, addr, wd, rd, err, lat, rdy);
      check({tag, "_lat"}, lat, (d == 0) ? 32'd1 : 32'd4);
      check({tag, "_err"}, err, exp_err);
      check({tag, "_data"}, rd, exp_rd);
   endtask

   initial begin
      logic [31:0] rd;
      logic        err;
      int          lat, seen;
      logic [3:0]  rdy;

      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = '0;
         req_wr_en[d] = 1'b0; req_op[d] = MEM_LW; req_wr_data[d] = '0;
      end
      repeat (3) @(posedge Clk);
      #1 rst[0] = 1'b0; rst[1] = 1'b0;
      @(negedge Clk);
      check("rst_ready", req_ready[0], 1'b1);
      check("rst_valid", rsp_valid[0], 1'b0);
      check("rst_err", rsp_err[0], 1'b0);
      check("rst_data", rsp_rd_data[0], 32'h0);
      check("rst_ready_ws3", req_ready[1], 1'b1);

      // Zero-wait-state instance: stores, loads and lane steering.
      do_op("sw_10", 0, 1'b1, MEM_SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
      do_op("lw_10", 0, 1'b0, MEM_LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
      do_op("lb_13", 0, 1'b0, MEM_LB, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
      do_op("lbu_13", 0, 1'b0, MEM_LB_U, 32'h13, 32'h0, 32'h000000DE, 1'b0);
      do_op("lh_10", 0, 1'b0, MEM_LH, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
      do_op("lhu_12", 0, 1'b0, MEM_LH_U, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
      do_op("sb_11", 0, 1'b1, MEM_SB, 32'h11, 32'h0000005A, 32'h0, 1'b0);
      do_op("lw_after_sb", 0, 1'b0, MEM_LW, 32'h10, 32'h0, 32'hDEAD5AEF, 1'b0);
      do_op("sh_12", 0, 1'b1, MEM_SH, 32'h12, 32'h1234A5A5, 32'h0, 1'b0);
      do_op("lw_after_sh", 0, 1'b0, MEM_LW, 32'h10, 32'h0, 32'hA5A55AEF, 1'b0);
      do_op("lb_12_neg", 0, 1'b0, MEM_LB, 32'h12, 32'h0, 32'hFFFFFFA5, 1'b0);

      // Address range boundary: last word is fine, first word past the array faults.
      do_op("sw_last", 0, 1'b1, MEM_SW, 32'hFFC, 32'h0BADF00D, 32'h0, 1'b0);
      do_op("lw_last", 0, 1'b0, MEM_LW, 32'hFFC, 32'h0, 32'h0BADF00D, 1'b0);
      do_op("lw_oob", 0, 1'b0, MEM_LW, 32'h1000, 32'h0, 32'h0, 1'b1);
      do_op("sw_oob", 0, 1'b1, MEM_SW, 32'h1000, 32'h11111111, 32'h0, 1'b1);
      do_op("lw_0_after_oob", 0, 1'b0, MEM_LW, 32'h0FFC, 32'h0, 32'h0BADF00D, 1'b0);

`ifdef DMEM_MISALIGN_CHECK_EN
      do_op("lw_12_mis", 0, 1'b0, MEM_LW, 32'h12, 32'h0, 32'h0, 1'b1);
      do_op("lh_11_mis", 0, 1'b0, MEM_LH, 32'h11, 32'h0, 32'h0, 1'b1);
      do_op("sw_12_mis", 0, 1'b1, MEM_SW, 32'h12, 32'h77777777, 32'h0, 1'b1);
      do_op("lw_10_kept", 0, 1'b0, MEM_LW, 32'h10, 32'h0, 32'hA5A55AEF, 1'b0);
`else
      do_op("lw_12_low_ign", 0, 1'b0, MEM_LW, 32'h12, 32'h0, 32'hA5A55AEF, 1'b0);
      do_op("lh_11_low_ign", 0, 1'b0, MEM_LH, 32'h11, 32'h0, 32'h00005AEF, 1'b0);
`endif

      // Back-to-back store then load of the same word, accepted in consecutive cycles.
      @(negedge Clk);
      req_valid[0] = 1'b1; req_wr_en[0] = 1'b1; req_op[0] = MEM_SW;
      req_addr[0] = 32'h20; req_wr_data[0] = 32'h11223344;
      @(posedge Clk);
      #1 req_wr_en[0] = 1'b0; req_op[0] = MEM_LW;
      @(negedge Clk);
      check("b2b_st_valid", rsp_valid[0], 1'b1);
      check("b2b_st_ready", req_ready[0], 1'b1);
      check("b2b_st_data", rsp_rd_data[0], 32'h0);
      @(posedge Clk);
      #1 req_valid[0] = 1'b0;
      @(negedge Clk);
      check("b2b_ld_valid", rsp_valid[0], 1'b1);
      check("b2b_ld_data", rsp_rd_data[0], 32'h11223344);
      @(negedge Clk);
      check("b2b_idle", rsp_valid[0], 1'b0);

      // Three-wait-state instance: latency and ready gap.
      do_op("ws3_sw_30", 1, 1'b1, MEM_SW, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0);
      access(1, 1'b0, MEM_LW, 32'h30, 32'h0, rd, err, lat, rdy);
      check("ws3_lw_lat", lat, 32'd4);
      check("ws3_lw_data", rd, 32'hCAFEF00D);
      check("ws3_ready_gap", rdy, 4'b1000);

      // Reset one cycle after a store is accepted: the store must vanish.
      @(negedge Clk);
      req_valid[1] = 1'b1; req_wr_en[1] = 1'b1; req_op[1] = MEM_SW;
      req_addr[1] = 32'h30; req_wr_data[1] = 32'h12345678;
      @(posedge Clk);
      #1 req_valid[1] = 1'b0;
      @(negedge Clk);
      check("abort_pre_ready", req_ready[1], 1'b0);
      rst[1] = 1'b1;
      #1;
      check("abort_rst_valid", rsp_valid[1], 1'b0);
      check("abort_rst_ready", req_ready[1], 1'b1);
      @(posedge Clk);
      #1 rst[1] = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         if (rsp_valid[1]) seen++;
      end
      check("abort_no_rsp", seen, 32'd0);
      do_op("ws3_lw_after_abort", 1, 1'b0, MEM_LW, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0);
      do_op("ws3_lw_oob", 1, 1'b0, MEM_LW, 32'h1000, 32'h0, 32'h0, 1'b1);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
